led_tick_gen: RTL and testbench
===============================

LED_TICK_GEN -- requirements
Module: led_tick_gen

Interface
REQ-001 Parameter NCH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter WIDTH, default 7, bit width of each channel's counter and divisor.
REQ-003 Parameter DEFAULT_DIV, default 10, divisor loaded into every channel at reset.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset; one clock; polarity and synchronicity fixed.
REQ-006 en  input  NCH  per-channel count enable.
REQ-007 mode  input  NCH  per-channel output mode: 0 = toggle (square wave), 1 = pulse.
REQ-008 div_ld  input  1  divisor write strobe.
REQ-009 div_sel  input  max(1,$clog2(NCH))  channel index for divisor write.
REQ-010 div_val  input  WIDTH  divisor value to write.
REQ-011 sync  input  1  phase-align strobe for all channels.
REQ-012 newclk  output  NCH  registered per-channel divided clock / pulse.
REQ-013 tick  output  NCH  registered one-cycle terminal-count strobe per channel.

Function
REQ-014 Each channel i SHALL hold a WIDTH-bit counter cnt[i] and a WIDTH-bit divisor div[i].
REQ-015 Terminal condition for channel i SHALL be en[i]=1 and cnt[i] >= div[i] (unsigned compare).
REQ-016 With en[i]=1 and not terminal, cnt[i] SHALL increment by 1 per cycle; on terminal, cnt[i] SHALL return to 0.
REQ-017 On terminal, tick[i] SHALL be 1 in the following cycle; tick[i] SHALL be 0 in every other cycle.
REQ-018 Toggle mode: newclk[i] SHALL invert on each terminal; output period SHALL be 2*(div[i]+1) cycles, 50% duty.
REQ-019 Pulse mode: newclk[i] SHALL equal the registered tick[i] (one-cycle high every div[i]+1 cycles).
REQ-020 div[i]=0 SHALL give terminal every enabled cycle (toggle: period 2; pulse: newclk held high).
REQ-021 With en[i]=0: cnt[i] holds, tick[i]=0, newclk[i] holds in toggle mode and is 0 in pulse mode.
REQ-022 div_ld=1 SHALL write div_val into div[div_sel] at the clock edge; new value used from the next cycle.
REQ-023 div_ld with div_sel >= NCH SHALL be ignored with no state change.
REQ-024 If cnt[i] exceeds a newly loaded smaller div[i], the >= compare SHALL force terminal on the next enabled cycle (no counter wrap past 2^WIDTH).
REQ-025 sync=1 SHALL set all cnt to 0, all newclk to 0, all tick to 0 at the next edge, regardless of en; divisors unchanged.
REQ-026 Simultaneous sync and div_ld SHALL apply both: counters cleared and divisor written.
REQ-027 Mode change on channel i SHALL take effect the next cycle; counter phase unaffected.
REQ-028 Channels SHALL be fully independent except for the shared sync and div_ld bus.

Reset
REQ-029 rst=1 SHALL set all cnt=0, all div=DEFAULT_DIV, all newclk=0, all tick=0 at the next edge.
REQ-030 rst SHALL take priority over sync, div_ld and counting; reset mid-period SHALL discard the partial count.
REQ-031 First terminal after reset release with en=1 SHALL occur DEFAULT_DIV+1 enabled cycles later.

Verification
REQ-032 Reset, en=4'b0001, mode=0, default div 10 -> newclk[0] toggles every 11 cycles (period 22), tick[0] one-cycle per toggle, other channels 0.
REQ-033 Load div_sel=2, div_val=3, en[2]=1, mode[2]=1 -> newclk[2]=tick[2] high 1 of every 4 cycles.
REQ-034 Channel 1 at cnt=8, load div 4 -> terminal next cycle, then period 5 per half-cycle thereafter.
REQ-035 Channels 0,1 running with div 10 and 6, pulse sync -> both newclk=0, counters 0, next ticks 11 and 7 cycles later.
REQ-036 Drop en[0] mid-count at cnt=5 for 3 cycles -> cnt frozen at 5, newclk held; resumes, terminal 6 enabled cycles later.
REQ-037 Assert rst with sync and div_ld=1 same cycle -> all divisors DEFAULT_DIV, outputs 0, load discarded.

Source files
------------

// File: rtl/led_tick_gen.sv
// Bank of independent programmable clock dividers with toggle or pulse output.
// Counters compare against a per-channel divisor and emit a tick on terminal count.
module led_tick_gen #(
  parameter  int NCH         = 4,
  parameter  int WIDTH       = 7,
  parameter  int DEFAULT_DIV = 10,
  localparam int SW          = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic [NCH-1:0]   mode,
  input  logic             div_ld,
  input  logic [SW-1:0]    div_sel,
  input  logic [WIDTH-1:0] div_val,
  input  logic             sync,
  output logic [NCH-1:0]   newclk,
  output logic [NCH-1:0]   tick
);

  logic [WIDTH-1:0] cnt [NCH];
  logic [WIDTH-1:0] div [NCH];
  logic [NCH-1:0]   term;

  // >= rather than == so a shrunk divisor never lets the count run off the end
  always_comb begin
    term = '0;
    for (int i = 0; i < NCH; i++)
      term[i] = en[i] && (cnt[i] >= div[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
        div[i] <= WIDTH'(DEFAULT_DIV);
      end
      newclk <= '0;
      tick   <= '0;
    end else begin
      // an out-of-range select matches no channel and is dropped
      for (int i = 0; i < NCH; i++)
        if (div_ld && (div_sel == SW'(i)))
          div[i] <= div_val;

      if (sync) begin
        for (int i = 0; i < NCH; i++)
          cnt[i] <= '0;
        newclk <= '0;
        tick   <= '0;
      end else begin
        for (int i = 0; i < NCH; i++) begin
          tick[i] <= term[i];
          if (en[i])
            cnt[i] <= term[i] ? '0 : cnt[i] + WIDTH'(1);
          if (mode[i])
            newclk[i] <= term[i];
          else
            newclk[i] <= newclk[i] ^ term[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_led_tick_gen.sv
// Scoreboarded random + directed bench for led_tick_gen.
// Stimulus pushes model predictions; a monitor pops and compares each cycle.
module tb_led_tick_gen;

  localparam int NCH   = 6;
  localparam int WIDTH = 7;
  localparam int DDIV  = 10;
  localparam int SW    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NCH-1:0]   en = '0;
  logic [NCH-1:0]   mode = '0;
  logic             div_ld = 1'b0;
  logic [SW-1:0]    div_sel = '0;
  logic [WIDTH-1:0] div_val = '0;
  logic             sync = 1'b0;
  logic [NCH-1:0]   newclk;
  logic [NCH-1:0]   tick;

  led_tick_gen #(
    .NCH(NCH), .WIDTH(WIDTH), .DEFAULT_DIV(DDIV)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .div_ld(div_ld), .div_sel(div_sel), .div_val(div_val),
    .sync(sync), .newclk(newclk), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] nc;
    logic [NCH-1:0] tk;
  } exp_t;

  exp_t q[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  // reference: each channel counts elapsed enabled cycles since its last
  // terminal and fires once that count has reached the divisor
  int  elapsed [NCH];
  int  divisor [NCH];
  bit  level   [NCH];
  bit  fired   [NCH];

  task automatic step(input logic [NCH-1:0] e, input logic [NCH-1:0] m,
                      input bit ld, input int sel, input int val,
                      input bit sy, input bit r);
    exp_t x;
    bit hit [NCH];
    @(negedge clk);
    en = e; mode = m; div_ld = ld;
    div_sel = SW'(sel); div_val = WIDTH'(val);
    sync = sy; rst = r;
    if (r) begin
      for (int i = 0; i < NCH; i++) begin
        elapsed[i] = 0; divisor[i] = DDIV;
        level[i] = 0; fired[i] = 0;
      end
    end else begin
      for (int i = 0; i < NCH; i++)
        hit[i] = e[i] && (elapsed[i] >= divisor[i]);
      if (ld && sel < NCH)
        divisor[sel] = val;
      for (int i = 0; i < NCH; i++) begin
        if (sy) begin
          elapsed[i] = 0; level[i] = 0; fired[i] = 0;
        end else begin
          fired[i] = hit[i];
          if (e[i]) elapsed[i] = hit[i] ? 0 : elapsed[i] + 1;
          if (m[i]) level[i] = hit[i];
          else if (hit[i]) level[i] = !level[i];
        end
      end
    end
    for (int i = 0; i < NCH; i++) begin
      x.nc[i] = level[i];
      x.tk[i] = fired[i];
    end
    q.push_back(x);
  endtask

  task automatic run(input logic [NCH-1:0] e, input logic [NCH-1:0] m,
                     input int n);
    for (int k = 0; k < n; k++) step(e, m, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        x = q.pop_front();
        compared++;
        if (newclk !== x.nc || tick !== x.tk) begin
          mismatched++;
          $display("FAIL outputs cycle %0d: newclk=%b tick=%b, expected newclk=%b tick=%b",
                   cyc, newclk, tick, x.nc, x.tk);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, %0d compared", compared);
    $fatal(1);
  end

  initial begin : stim
    logic [NCH-1:0] e, m;
    int ld, sel, val;
    step('0, '0, 0, 0, 0, 0, 1);
    // ch0 toggle, default divisor
    run(6'b000001, '0, 50);
    // ch2 pulse with divisor 3
    step(6'b000001, '0, 1, 2, 3, 0, 0);
    run(6'b000101, 6'b000100, 20);
    // ch1 reaches 8 then divisor shrinks to 4
    step('0, '0, 0, 0, 0, 1, 0);
    run(6'b000010, '0, 8);
    step(6'b000010, '0, 1, 1, 4, 0, 0);
    run(6'b000010, '0, 25);
    // ch0 div 10, ch1 div 6, then sync mid-period
    step(6'b000011, '0, 1, 1, 6, 0, 0);
    run(6'b000011, '0, 17);
    step(6'b000011, '0, 0, 0, 0, 1, 0);
    run(6'b000011, '0, 30);
    // en[0] dropped at cnt=5 for three cycles
    step(6'b000001, '0, 0, 0, 0, 1, 0);
    run(6'b000001, '0, 5);
    run(6'b000000, '0, 3);
    run(6'b000001, '0, 20);
    // divisor 0 in both modes
    step(6'b110000, 6'b100000, 1, 4, 0, 0, 0);
    step(6'b110000, 6'b100000, 1, 5, 0, 0, 0);
    run(6'b110000, 6'b100000, 8);
    // out-of-range selects are ignored
    step(6'b111111, '0, 1, 6, 1, 0, 0);
    step(6'b111111, '0, 1, 7, 2, 0, 0);
    run(6'b111111, '0, 15);
    // reset beats sync and load together
    step(6'b111111, '0, 1, 0, 2, 1, 1);
    run(6'b111111, 6'b001010, 30);
    // random traffic
    m = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NCH; i++)
        e[i] = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 99) < 5) m = NCH'($urandom);
      ld = ($urandom_range(0, 99) < 10) ? 1 : 0;
      sel = $urandom_range(0, 7);
      val = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 15)
                                       : $urandom_range(0, 127);
      step(e, m, ld[0], sel, val,
           $urandom_range(0, 99) < 2,
           $urandom_range(0, 199) < 1);
    end
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
